// File: rtl/elevator_scheduler.sv
// Three-floor elevator scheduler: latches hall calls, serves them in SCAN order,
// times travel and door dwell in tick units, and handles the emergency stop.
module elevator_scheduler #(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3,
  parameter int CW           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       g_f,
  input  logic       f_f,
  input  logic       s_f,
  input  logic       emerg_in,
  output logic [1:0] cur_floor,
  output logic [3:0] floor_disp,
  output logic [2:0] next_LED,
  output logic [2:0] pending,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic       emerg_out
);

  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR, EMERG} state_t;

  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_TICKS - 1);

  state_t        state_reg, state_next;
  logic [1:0]    floor_reg, floor_next;
  logic          dir_reg, dir_next;      // 1 = up
  logic [2:0]    pend_reg, pend_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    led_reg, led_next;

  logic [2:0]    calls, pend_in, cur_oh, arrive_oh;
  logic [1:0]    arrive_floor, target;

  function automatic logic call_above(input logic [1:0] fl, input logic [2:0] p);
    case (fl)
      2'd0:    call_above = p[1] | p[2];
      2'd1:    call_above = p[2];
      default: call_above = 1'b0;
    endcase
  endfunction

  function automatic logic call_below(input logic [1:0] fl, input logic [2:0] p);
    case (fl)
      2'd1:    call_below = p[0];
      2'd2:    call_below = p[0] | p[1];
      default: call_below = 1'b0;
    endcase
  endfunction

  assign calls        = {s_f, f_f, g_f};
  assign pend_in      = pend_reg | calls;
  assign cur_oh       = 3'b001 << floor_reg;
  assign arrive_floor = (state_reg == MOVE_DOWN) ? floor_reg - 2'd1 : floor_reg + 2'd1;
  assign arrive_oh    = 3'b001 << arrive_floor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      floor_reg <= 2'd0;
      dir_reg   <= 1'b1;
      pend_reg  <= 3'b000;
      cnt_reg   <= '0;
      led_reg   <= 3'b001;
    end else begin
      state_reg <= state_next;
      floor_reg <= floor_next;
      dir_reg   <= dir_next;
      pend_reg  <= pend_next;
      cnt_reg   <= cnt_next;
      led_reg   <= led_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    floor_next = floor_reg;
    dir_next   = dir_reg;
    pend_next  = pend_in;
    cnt_next   = cnt_reg;
    if (state_reg == EMERG) begin
      pend_next = 3'b000;
      cnt_next  = '0;
      if (!emerg_in) state_next = IDLE;
    end else if (emerg_in) begin
      // Emergency beats arrival and door expiry in the same cycle.
      state_next = EMERG;
      pend_next  = 3'b000;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
          if (|(pend_in & cur_oh)) begin
            state_next = DOOR;
            pend_next  = pend_in & ~cur_oh;
          end else if (dir_reg && call_above(floor_reg, pend_in)) begin
            state_next = MOVE_UP;
          end else if (call_below(floor_reg, pend_in)) begin
            state_next = MOVE_DOWN;
            dir_next   = 1'b0;
          end else if (call_above(floor_reg, pend_in)) begin
            state_next = MOVE_UP;
            dir_next   = 1'b1;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (tick) begin
            if (cnt_reg == TRAVEL_LAST) begin
              floor_next = arrive_floor;
              cnt_next   = '0;
              if (|(pend_in & arrive_oh)) begin
                state_next = DOOR;
                pend_next  = pend_in & ~arrive_oh;
              end else if ((state_reg == MOVE_UP) ? call_above(arrive_floor, pend_in)
                                                  : call_below(arrive_floor, pend_in)) begin
                state_next = state_reg;
              end else begin
                state_next = IDLE;
              end
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        DOOR: begin
          // A call for this floor keeps the door open and restarts the dwell.
          pend_next = pend_in & ~cur_oh;
          if (|(calls & cur_oh)) begin
            cnt_next = '0;
          end else if (tick) begin
            if (cnt_reg == DOOR_LAST) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    target = floor_next;
    if (state_next == MOVE_UP)   target = floor_next + 2'd1;
    if (state_next == MOVE_DOWN) target = floor_next - 2'd1;
    led_next = 3'b001 << target;
  end

  always_comb begin
    motor_up   = (state_reg == MOVE_UP);
    motor_down = (state_reg == MOVE_DOWN);
    door_open  = (state_reg == DOOR);
    emerg_out  = (state_reg == EMERG);
  end

  assign cur_floor  = floor_reg;
  assign floor_disp = {2'b00, floor_reg};
  assign next_LED   = led_reg;
  assign pending    = pend_reg;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed test-plan scenarios followed by random
// traffic, all compared cycle by cycle against a tick-countdown reference model.
module tb_elevator_scheduler;
  localparam int TT = 4;
  localparam int DT = 3;
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3, M_EMERG = 4;

  logic clk = 1'b0, reset = 1'b0, tick = 1'b0;
  logic g_f = 1'b0, f_f = 1'b0, s_f = 1'b0, emerg_in = 1'b0;
  logic [1:0] cur_floor;
  logic [3:0] floor_disp;
  logic [2:0] next_LED, pending;
  logic motor_up, motor_down, door_open, emerg_out;

  int checks = 0;
  int failures = 0;

  int m_mode, m_floor, m_left;
  bit m_up;
  bit [2:0] m_pend;

  elevator_scheduler #(.TRAVEL_TICKS(TT), .DOOR_TICKS(DT), .CW(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .g_f(g_f), .f_f(f_f), .s_f(s_f),
    .emerg_in(emerg_in), .cur_floor(cur_floor), .floor_disp(floor_disp),
    .next_LED(next_LED), .pending(pending), .motor_up(motor_up),
    .motor_down(motor_down), .door_open(door_open), .emerg_out(emerg_out)
  );

  always #5 clk = ~clk;

  function automatic bit any_above(int fl, bit [2:0] p);
    for (int k = fl + 1; k < 3; k++) if (p[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(int fl, bit [2:0] p);
    for (int k = 0; k < fl; k++) if (p[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_floor = 0; m_up = 1'b1; m_pend = 3'b000; m_left = 0;
  endtask

  task automatic open_door();
    m_mode = M_DOOR; m_pend[m_floor] = 1'b0; m_left = DT;
  endtask

  task automatic model_step(bit [2:0] c, bit em, bit tk);
    if (m_mode == M_EMERG) begin
      if (!em) m_mode = M_IDLE;
    end else if (em) begin
      m_mode = M_EMERG; m_pend = 3'b000;
    end else begin
      m_pend = m_pend | c;
      case (m_mode)
        M_IDLE: begin
          if (m_pend[m_floor]) open_door();
          else if (m_up && any_above(m_floor, m_pend)) begin m_mode = M_UP; m_left = TT; end
          else if (any_below(m_floor, m_pend)) begin m_mode = M_DOWN; m_up = 1'b0; m_left = TT; end
          else if (any_above(m_floor, m_pend)) begin m_mode = M_UP; m_up = 1'b1; m_left = TT; end
        end
        M_UP, M_DOWN: if (tk) begin
          m_left--;
          if (m_left == 0) begin
            m_floor += (m_mode == M_UP) ? 1 : -1;
            if (m_pend[m_floor]) open_door();
            else if ((m_mode == M_UP) ? any_above(m_floor, m_pend) : any_below(m_floor, m_pend)) m_left = TT;
            else m_mode = M_IDLE;
          end
        end
        M_DOOR: begin
          if (c[m_floor]) begin m_pend[m_floor] = 1'b0; m_left = DT; end
          else if (tk) begin
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_model(string ctx);
    int tgt;
    tgt = m_floor + ((m_mode == M_UP) ? 1 : (m_mode == M_DOWN) ? -1 : 0);
    check({ctx, ".cur_floor"},  {6'b0, cur_floor},  8'(m_floor));
    check({ctx, ".floor_disp"}, {4'b0, floor_disp}, 8'(m_floor));
    check({ctx, ".next_LED"},   {5'b0, next_LED},   8'(1 << tgt));
    check({ctx, ".pending"},    {5'b0, pending},    {5'b0, m_pend});
    check({ctx, ".outs"}, {4'b0, motor_up, motor_down, door_open, emerg_out},
          {4'b0, m_mode == M_UP, m_mode == M_DOWN, m_mode == M_DOOR, m_mode == M_EMERG});
  endtask

  task automatic step(string ctx, bit g, bit f, bit s, bit em, bit tk);
    g_f = g; f_f = f; s_f = s; emerg_in = em; tick = tk;
    @(posedge clk);
    model_step({s, f, g}, em, tk);
    #1;
    compare_model(ctx);
    g_f = 1'b0; f_f = 1'b0; s_f = 1'b0;
  endtask

  task automatic run(string ctx, int n);
    for (int i = 0; i < n; i++) step(ctx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Asserts reset between clock edges and checks outputs before the next edge.
  task automatic async_reset(string ctx);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check({ctx, ".rst_floor"}, {6'b0, cur_floor}, 8'd0);
    check({ctx, ".rst_pend"},  {5'b0, pending},   8'd0);
    check({ctx, ".rst_led"},   {5'b0, next_LED},  8'd1);
    check({ctx, ".rst_mup"},   {7'b0, motor_up},  8'd0);
    compare_model(ctx);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit em_level;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    @(negedge clk);
    reset = 1'b1;

    step("single", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run("single", 20);
    check("single.final_floor", {6'b0, cur_floor}, 8'd2);
    check("single.final_led",   {5'b0, next_LED},  8'd4);

    step("home", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run("home", 20);

    step("inter", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run("inter", 2);
    step("inter", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run("inter", 20);

    step("scan_setup", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run("scan_setup", 20);
    step("scan_setup", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run("scan_setup", 12);
    step("scan", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run("scan", 30);

    step("emerg", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run("emerg", 2);
    step("emerg", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("emerg.out", {7'b0, emerg_out}, 8'd1);
    check("emerg.pend", {5'b0, pending}, 8'd0);
    step("emerg_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step("emerg_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("emerg_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run("emerg_rel", 3);

    step("reopen", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run("reopen", 5);
    step("reopen", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run("reopen", 6);

    step("rst_move", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run("rst_move", 2);
    async_reset("rst_move");

    em_level = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) em_level = ~em_level;
      step("rand", $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 11) == 0, em_level, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 399) == 0) async_reset("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Request scheduler and motion sequencer for the three-floor elevator (ground, first, second).
- Latches hall calls and picks the next target floor using direction-preserving (SCAN) order.
- Times travel between floors and door dwell, and handles the emergency stop.
- Outputs drive the floor display path (4-bit floor code), the next-floor one-hot LEDs and the motor/door indicators.
- Runs on the divided system clock; timing is counted in `tick` enables.

Parameters:
- TRAVEL_TICKS, 4: ticks to move one floor (≥1).
- DOOR_TICKS, 3: ticks the door stays open (≥1).
- CW, 4: width of the shared travel/door counter; must hold max(TRAVEL_TICKS, DOOR_TICKS)-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk timing enable.
- g_f  in  1  ground-floor call (level, sampled every clk).
- f_f  in  1  first-floor call.
- s_f  in  1  second-floor call.
- emerg_in  in  1  emergency stop (level).
- cur_floor  out  2  current floor, 0..2.
- floor_disp  out  4  {2'b00, cur_floor}, goes to the display path.
- next_LED  out  3  one-hot target floor (001=G, 010=1, 100=2).
- pending  out  3  latched calls, bit i = floor i.
- motor_up  out  1  high in MOVE_UP.
- motor_down  out  1  high in MOVE_DOWN.
- door_open  out  1  high in DOOR.
- emerg_out  out  1  high in EMERG.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, cur_floor=0, dir=up, pending=000, cnt=0.
  - next_LED=001, all motor/door/emerg outputs 0.
- Request latch, every clk outside EMERG: pending |= {s_f, f_f, g_f}.
  - The bit for cur_floor is cleared on entry to DOOR.
  - A call for cur_floor while in DOOR keeps that bit clear and reloads cnt=0, so dwell restarts.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR, EMERG. motor_up, motor_down, door_open and emerg_out are Moore decodes of the state register.
- IDLE decision (one clk, evaluated in priority order):
  - emerg_in → EMERG.
  - pending[cur] → DOOR.
  - dir=up and call above → MOVE_UP.
  - call below → MOVE_DOWN, dir=down.
  - call above → MOVE_UP, dir=up.
  - else stay in IDLE.
  - cnt=0 on every exit.
- MOVE_x:
  - cnt increments on tick.
  - On a tick with cnt==TRAVEL_TICKS-1: cur_floor±1, cnt=0, then same-cycle arrival decision:
    - pending[new floor] → DOOR, clearing that bit;
    - else call further in the same direction → stay in MOVE_x;
    - else → IDLE.
  - cur_floor never leaves 0..2. MOVE_UP is never entered at floor 2, nor MOVE_DOWN at 0.
- DOOR: cnt increments on tick; on a tick with cnt==DOOR_TICKS-1 → IDLE, cnt=0.
- EMERG:
  - Entered from any state on the clk where emerg_in=1; this has highest priority and overrides arrival or door expiry in the same cycle.
  - On entry: pending=000, cnt=0. An interrupted travel is abandoned and cur_floor keeps its last value.
  - Calls are ignored while in EMERG.
  - emerg_in=0 → IDLE on the next clk; dir is preserved.
- next_LED: one-hot of target.
  - Target is cur_floor+1 in MOVE_UP, cur_floor-1 in MOVE_DOWN, cur_floor otherwise.
  - Registered, updated each clk.
- tick is ignored in IDLE and EMERG.
- Async reset asserted mid-operation returns everything to reset values immediately.

Test Plan:
- Reset: pulse reset=0 during MOVE_UP → same edge cur_floor=0, pending=000, next_LED=001, motor_up=0.
- Single call (TRAVEL_TICKS=4, DOOR_TICKS=3), s_f pulse at floor 0:
  - MOVE_UP, next_LED=010; cur_floor=1 after 4 ticks, next_LED=100; cur_floor=2 after 8 ticks.
  - Then DOOR with pending=000, door_open=1 for 3 ticks, then IDLE with next_LED=100.
- Intermediate stop: moving 0→2, press f_f before the first arrival → stops at floor 1 in DOOR, pending=100, then resumes MOVE_UP to floor 2.
- SCAN order: at floor 1 in IDLE, dir=up, pending=101 → goes to floor 2 first, then back down to floor 0.
- Emergency mid-travel: emerg_in=1 at tick 2 of the 0→1 move:
  - next clk state=EMERG, emerg_out=1, motor_up=0, pending=000, cur_floor=0.
  - A g_f press while emergency is active is ignored.
  - Release → IDLE.
- Door reopen: f_f pressed during DOOR at floor 1 → door_open stays 1 for a full DOOR_TICKS from the press.
